mmul: RTL and testbench

MMUL -- requirements
Module: mmul

---
 rtl/mmul.sv | 159 +++++++++++++++
 tb/tb_mmul.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/mmul.sv
// mmul: sequential 24x24 mantissa multiplier with normalization.
//
// The operands are captured when enable rises in IDLE. The product is then
// built one multiplier bit per clock (LSB first, 24 steps) and normalized on
// the following edge. A result therefore appears 25 edges after capture,
// whatever the operand values are.
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   a, b      24-bit mantissas, hidden bit at [23]
//   enable    level request, held high until done is seen
//   mantissa  normalized product mantissa, hidden bit at [23]
//   exponent  two's-complement exponent adjustment (0, 1 or 2)
//   done      result valid, held until enable falls
//
// Build option: define MMUL_ROUND_EN for round-to-nearest-even in the
// normalization step. Without it, the normalization step truncates.
module mmul (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] a,
  input  logic [23:0] b,
  input  logic        enable,
  output logic [23:0] mantissa,
  output logic [8:0]  exponent,
  output logic        done
);

  typedef enum logic [1:0] {StIdle, StMul, StNorm, StDone} state_e;

  state_e      state_q, state_d;
  logic [23:0] a_q, a_d, b_q, b_d;
  logic [47:0] acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [23:0] mant_q, mant_d;
  logic [8:0]  exp_q, exp_d;
  logic        done_q, done_d;

  logic [23:0] trunc_mant, norm_mant;
  logic [8:0]  trunc_exp, norm_exp;
`ifdef MMUL_ROUND_EN
  logic        guard, sticky;
  logic [24:0] rounded;
`endif

  // Normalization of the finished product held in the accumulator.
  always_comb begin
    trunc_mant = '0;
    trunc_exp  = '0;
`ifdef MMUL_ROUND_EN
    guard  = 1'b0;
    sticky = 1'b0;
`endif
    if (acc_q[47]) begin
      trunc_mant = acc_q[47:24];
      trunc_exp  = 9'd1;
`ifdef MMUL_ROUND_EN
      guard  = acc_q[23];
      sticky = |acc_q[22:0];
`endif
    end else if (acc_q[46]) begin
      trunc_mant = acc_q[46:23];
`ifdef MMUL_ROUND_EN
      guard  = acc_q[22];
      sticky = |acc_q[21:0];
`endif
    end
`ifdef MMUL_ROUND_EN
    rounded = {1'b0, trunc_mant} + {24'd0, guard & (sticky | trunc_mant[0])};
    if (rounded[24]) begin
      // Rounding overflowed the field: renormalize to 1.0 one binade up.
      norm_mant = 24'h80_0000;
      norm_exp  = trunc_exp + 9'd1;
    end else begin
      norm_mant = rounded[23:0];
      norm_exp  = trunc_exp;
    end
`else
    norm_mant = trunc_mant;
    norm_exp  = trunc_exp;
`endif
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    mant_d  = mant_q;
    exp_d   = exp_q;
    done_d  = done_q;
    unique case (state_q)
      StIdle: begin
        if (enable) begin
          a_d     = a;
          b_d     = b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = StMul;
        end
      end
      StMul: begin
        if (!enable) begin
          state_d = StIdle;
        end else begin
          if (b_q[cnt_q]) acc_d = acc_q + ({24'd0, a_q} << cnt_q);
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd23) state_d = StNorm;
        end
      end
      StNorm: begin
        if (!enable) begin
          state_d = StIdle;
        end else begin
          mant_d  = norm_mant;
          exp_d   = norm_exp;
          done_d  = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        if (!enable) begin
          done_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      mant_q  <= '0;
      exp_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      mant_q  <= mant_d;
      exp_q   <= exp_d;
      done_q  <= done_d;
    end
  end

  assign mantissa = mant_q;
  assign exponent = exp_q;
  assign done     = done_q;

endmodule

// File: tb/tb_mmul.sv
// tb_mmul: self-checking bench for mmul. Directed vectors from a table,
// randomized operands against a behavioural model, and hand-written
// reset / abort sequences. Honours MMUL_ROUND_EN like the design.
module tb_mmul;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [23:0] a, b;
  logic [23:0] mantissa;
  logic [8:0]  exponent;
  logic        done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mmul dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a),
    .b        (b),
    .enable   (enable),
    .mantissa (mantissa),
    .exponent (exponent),
    .done     (done)
  );

  typedef struct {
    logic [23:0] va;
    logic [23:0] vb;
    logic [23:0] m;
    logic [8:0]  e;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Reference: exact product by plain arithmetic, normalize by magnitude,
  // round-to-nearest-even via remainder against the half-ulp.
  function automatic void model(input logic [23:0] ma, input logic [23:0] mb,
                                output logic [23:0] m, output logic [8:0] e);
    logic [63:0] p, q;
    int s;
`ifdef MMUL_ROUND_EN
    logic [63:0] rem, half;
`endif
    p = {40'd0, ma} * {40'd0, mb};
    if (p >= 64'h8000_0000_0000) begin
      s = 24; e = 9'd1;
    end else if (p >= 64'h4000_0000_0000) begin
      s = 23; e = 9'd0;
    end else begin
      m = '0; e = '0;
      return;
    end
    q = p >> s;
`ifdef MMUL_ROUND_EN
    rem  = p - (q << s);
    half = 64'd1 << (s - 1);
    if (rem > half || (rem == half && q[0])) q = q + 1;
    if (q == 64'h100_0000) begin
      q = 64'h80_0000;
      e = e + 9'd1;
    end
`endif
    m = q[23:0];
  endfunction

  // One full transaction from IDLE: latency, result, hold, and release.
  task automatic run_op(input string name, input logic [23:0] ta, input logic [23:0] tb_v,
                        input logic [23:0] em, input logic [8:0] ee);
    @(negedge clk);
    a = ta; b = tb_v; enable = 1'b1;
    @(posedge clk);              // edge C
    @(negedge clk);
    a = ~ta; b = $urandom;       // must not disturb the result in progress
    repeat (24) @(posedge clk);  // C+1 .. C+24
    @(negedge clk);
    check({name, " done_early"}, {63'd0, done}, 64'd0);
    @(posedge clk);              // C+25
    @(negedge clk);
    check({name, " done"}, {63'd0, done}, 64'd1);
    check({name, " mantissa"}, {40'd0, mantissa}, {40'd0, em});
    check({name, " exponent"}, {55'd0, exponent}, {55'd0, ee});
    repeat (3) @(negedge clk);
    check({name, " hold_done"}, {63'd0, done}, 64'd1);
    check({name, " hold_mant"}, {40'd0, mantissa}, {40'd0, em});
    enable = 1'b0;
    @(negedge clk);
    check({name, " release_done"}, {63'd0, done}, 64'd0);
    check({name, " release_mant"}, {40'd0, mantissa}, {40'd0, em});
    check({name, " release_exp"}, {55'd0, exponent}, {55'd0, ee});
  endtask

  vec_t vecs[6];

  initial begin
    logic [23:0] ra, rb, rm;
    logic [8:0]  re;
    int          done_seen;

    vecs[0] = '{24'h80_0000, 24'h80_0000, 24'h80_0000, 9'd0};
    vecs[1] = '{24'hC0_0000, 24'hC0_0000, 24'h90_0000, 9'd1};
    vecs[2] = '{24'hFF_FFFF, 24'hFF_FFFF, 24'hFF_FFFE, 9'd1};
`ifdef MMUL_ROUND_EN
    vecs[3] = '{24'hC0_0001, 24'h80_0001, 24'hC0_0003, 9'd0};
`else
    vecs[3] = '{24'hC0_0001, 24'h80_0001, 24'hC0_0002, 9'd0};
`endif
    vecs[4] = '{24'h00_0000, 24'hAB_CDEF, 24'h00_0000, 9'd0};
    vecs[5] = '{24'h80_0000, 24'hFF_FFFF, 24'hFF_FFFF, 9'd0};

    rst_n = 1'b0; enable = 1'b0; a = '0; b = '0;
    #1;
    check("reset mantissa", {40'd0, mantissa}, 64'd0);
    check("reset exponent", {55'd0, exponent}, 64'd0);
    check("reset done", {63'd0, done}, 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++)
      run_op($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb, vecs[i].m, vecs[i].e);

    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 4 != 3) begin
        ra[23] = 1'b1;
        rb[23] = 1'b1;
      end
      model(ra, rb, rm, re);
      run_op($sformatf("rand%0d", i), ra, rb, rm, re);
    end

    // Reset in the middle of MUL clears everything immediately.
    run_op("pre_reset", 24'hC0_0000, 24'hC0_0000, 24'h90_0000, 9'd1);
    @(negedge clk);
    a = 24'hC0_0000; b = 24'hC0_0000; enable = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midreset mantissa", {40'd0, mantissa}, 64'd0);
    check("midreset exponent", {55'd0, exponent}, 64'd0);
    check("midreset done", {63'd0, done}, 64'd0);
    repeat (30) @(negedge clk);
    check("inreset done", {63'd0, done}, 64'd0);
    enable = 1'b0;
    rst_n = 1'b1;
    run_op("post_reset", 24'hC0_0000, 24'hC0_0000, 24'h90_0000, 9'd1);

    // Dropping enable mid-operation aborts without raising done.
    @(negedge clk);
    a = 24'hFF_FFFF; b = 24'hFF_FFFF; enable = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk);
    enable = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("abort done_seen", 64'(done_seen), 64'd0);
    check("abort mant_kept", {40'd0, mantissa}, 64'h90_0000);
    check("abort exp_kept", {55'd0, exponent}, 64'd1);
    run_op("post_abort", vecs[2].va, vecs[2].vb, vecs[2].m, vecs[2].e);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
